// File: rtl/cic_reconfig_sequencer.sv
// cic_reconfig_sequencer: run-time CIC ratio/mask reconfiguration sequencer.
// Holds the filter in reset, drops settling beats, then reopens the stream.
module cic_reconfig_sequencer #(
    parameter int unsigned RESET_CYCLES   = 16,
    parameter int unsigned SETTLE_SAMPLES = 8,
    parameter int unsigned SETTLE_TIMEOUT = 65535,
    parameter logic [31:0] DEFAULT_RATIO  = 32'd1,
    parameter logic [2:0]  DEFAULT_MASK   = 3'b000
) (
    input  logic        adc_clk,
    input  logic        adc_rst,
    input  logic        cfg_update,
    input  logic [31:0] cfg_decimation_ratio,
    input  logic [2:0]  cfg_filter_mask,
    input  logic        cfg_apply_on_pps,
    input  logic        pps_edge,
    output logic [31:0] filter_decimation_ratio,
    output logic [2:0]  filter_mask,
    output logic        filter_reset,
    input  logic [3:0]  s_dec_valid,
    input  logic [63:0] s_dec_data,
    output logic [3:0]  m_dec_valid,
    output logic [63:0] m_dec_data,
    output logic        m_retune_tag,
    output logic        busy,
    output logic        cfg_error,
    output logic        settle_timeout,
    output logic [15:0] reconfig_count
);

    typedef enum logic [1:0] {
        WAIT_PPS,
        HOLD,
        SETTLE,
        RUN
    } state_t;

    state_t      state;
    logic [31:0] hold_cnt;
    logic [31:0] beat_cnt;
    logic [31:0] settle_cnt;
    logic [31:0] shadow_ratio;
    logic [2:0]  shadow_mask;
    logic        tag_pending;

    logic accept;
    logic reject;
    logic beat;

    // Classify the incoming request and the current filter beat.
    always_comb begin
        accept = cfg_update && (cfg_decimation_ratio != 32'd0);
        reject = cfg_update && (cfg_decimation_ratio == 32'd0);
        beat   = |s_dec_valid;
    end

    // Sequencer state, filter controls and gated output stream.
    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            state                   <= HOLD;
            hold_cnt                <= '0;
            beat_cnt                <= '0;
            settle_cnt              <= '0;
            shadow_ratio            <= DEFAULT_RATIO;
            shadow_mask             <= DEFAULT_MASK;
            tag_pending             <= 1'b0;
            filter_reset            <= 1'b1;
            filter_decimation_ratio <= DEFAULT_RATIO;
            filter_mask             <= DEFAULT_MASK;
            m_dec_valid             <= '0;
            m_dec_data              <= '0;
            m_retune_tag            <= 1'b0;
            busy                    <= 1'b1;
            cfg_error               <= 1'b0;
            settle_timeout          <= 1'b0;
            reconfig_count          <= '0;
        end else begin
            cfg_error    <= reject;
            m_retune_tag <= 1'b0;
            m_dec_valid  <= '0;
            if (accept) begin
                // Newest request always restarts the sequence.
                shadow_ratio   <= cfg_decimation_ratio;
                shadow_mask    <= cfg_filter_mask;
                settle_timeout <= 1'b0;
                tag_pending    <= 1'b0;
                busy           <= 1'b1;
                if (cfg_apply_on_pps) begin
                    state <= WAIT_PPS;
                end else begin
                    state                   <= HOLD;
                    hold_cnt                <= '0;
                    filter_reset            <= 1'b1;
                    filter_decimation_ratio <= cfg_decimation_ratio;
                    filter_mask             <= cfg_filter_mask;
                end
            end else begin
                unique case (state)
                    WAIT_PPS: begin
                        if (pps_edge) begin
                            state                   <= HOLD;
                            hold_cnt                <= '0;
                            filter_reset            <= 1'b1;
                            filter_decimation_ratio <= shadow_ratio;
                            filter_mask             <= shadow_mask;
                        end
                    end
                    HOLD: begin
                        if (hold_cnt == RESET_CYCLES - 1) begin
                            state        <= SETTLE;
                            filter_reset <= 1'b0;
                            beat_cnt     <= '0;
                            settle_cnt   <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 32'd1;
                        end
                    end
                    SETTLE: begin
                        settle_cnt <= settle_cnt + 32'd1;
                        if (beat) begin
                            beat_cnt <= beat_cnt + 32'd1;
                        end
                        if (beat && (beat_cnt == SETTLE_SAMPLES - 1)) begin
                            state          <= RUN;
                            busy           <= 1'b0;
                            tag_pending    <= 1'b1;
                            reconfig_count <= reconfig_count + 16'd1;
                        end else if (settle_cnt == SETTLE_TIMEOUT - 1) begin
                            state          <= RUN;
                            busy           <= 1'b0;
                            tag_pending    <= 1'b1;
                            settle_timeout <= 1'b1;
                            reconfig_count <= reconfig_count + 16'd1;
                        end
                    end
                    RUN: begin
                        m_dec_valid <= s_dec_valid;
                        m_dec_data  <= s_dec_data;
                        if (beat) begin
                            m_retune_tag <= tag_pending;
                            tag_pending  <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/cic_reconfig_sequencer.md
# cic_reconfig_sequencer

Sequences run-time reconfiguration of a decimating CIC filter pair on the ADC receive path. It sits between the register block's CIC configuration outputs and the filter. On each software update it holds the filter in reset, applies the new ratio and mask, and discards the post-reset transient. It then re-opens the decimated sample stream toward the ADC packetiser and tags the first valid sample. Updates can optionally be aligned to a PPS edge.

## Interface
- RESET_CYCLES, 16: cycles `filter_reset` is held high per reconfiguration (≥2).
- SETTLE_SAMPLES, 8: decimated output beats discarded after reset release (≥1).
- SETTLE_TIMEOUT, 65535: max cycles in SETTLE before forced exit.
- DEFAULT_RATIO, 1: decimation ratio applied at reset.
- DEFAULT_MASK, 3'b000: filter mask applied at reset.

Ports:
- adc_clk  in  1  sole clock.
- adc_rst  in  1  reset; synchronous, active-high.
- cfg_update  in  1  one-cycle pulse: new request present on cfg_* inputs.
- cfg_decimation_ratio  in  32  requested ratio.
- cfg_filter_mask  in  3  requested mask.
- cfg_apply_on_pps  in  1  defer the request to the next `pps_edge`.
- pps_edge  in  1  one-cycle PPS pulse.
- filter_decimation_ratio  out  32  ratio applied to the filter.
- filter_mask  out  3  mask applied to the filter.
- filter_reset  out  1  filter reset (active-high).
- s_dec_valid  in  4  per-channel decimated valids from the filter.
- s_dec_data  in  64  decimated data, 4×16.
- m_dec_valid  out  4  gated valids to the packetiser.
- m_dec_data  out  64  registered data.
- m_retune_tag  out  1  high with the first forwarded beat after a reconfiguration.
- busy  out  1  high in every state except RUN.
- cfg_error  out  1  one-cycle pulse when a request is rejected.
- settle_timeout  out  1  sticky; set on a forced SETTLE exit, cleared by the next accepted request.
- reconfig_count  out  16  completed reconfigurations; wraps.

## Operation
- States: WAIT_PPS, HOLD, SETTLE, RUN.
- Reset values:
  - state HOLD with hold counter 0.
  - filter_reset=1, filter_decimation_ratio=DEFAULT_RATIO, filter_mask=DEFAULT_MASK.
  - m_dec_valid=0, m_dec_data=0, m_retune_tag=0, busy=1, cfg_error=0, settle_timeout=0, reconfig_count=0.
  - Leaving reset therefore always runs one full HOLD/SETTLE sequence.
- Request acceptance:
  - A `cfg_update` with `cfg_decimation_ratio==0` is rejected: `cfg_error` pulses and nothing else changes.
  - Otherwise the ratio and mask are latched into a pending shadow.
  - Then: if `cfg_apply_on_pps` is set, go to WAIT_PPS; else go to HOLD.
  - This applies in every state. A request during HOLD, SETTLE or WAIT_PPS aborts the sequence in progress and restarts with the newest values. Only the last request is kept.
- WAIT_PPS:
  - Previous config stays applied and `filter_reset` stays at its current value.
  - Output gating stays as entered (closed).
  - On `pps_edge`, go to HOLD.
- HOLD:
  - On entry, filter_decimation_ratio and filter_mask take the shadow values and filter_reset=1.
  - Stay for exactly RESET_CYCLES cycles, then go to SETTLE.
- SETTLE:
  - filter_reset=0.
  - Each cycle with s_dec_valid≠0 is one discarded beat.
  - After SETTLE_SAMPLES discarded beats, go to RUN; the beat that completes the count is also discarded.
  - If SETTLE_TIMEOUT cycles elapse first, go to RUN and set `settle_timeout`.
  - Entering RUN increments reconfig_count, modulo 2^16.
- RUN: m_dec_valid = s_dec_valid and m_dec_data = s_dec_data, both registered. The first beat with any valid bit set carries m_retune_tag=1.
- In every state other than RUN, m_dec_valid=0.
- cfg_update and pps_edge in the same cycle in WAIT_PPS: the request wins. The shadow updates, and the sequence goes to HOLD only if cfg_apply_on_pps=0; otherwise it stays in WAIT_PPS.

## Timing
- Request accepted in cycle t (no PPS deferral):
  - At t+1: filter_reset=1, new ratio/mask on the outputs, busy=1, m_dec_valid=0.
  - filter_reset falls at t+1+RESET_CYCLES.
- The data path has 1-cycle latency: s_dec_* in cycle n appears on m_dec_* in n+1.
- The transition out of RUN takes effect on outputs one cycle after the accepting edge, so no valid beat from the filter's new configuration is ever forwarded untagged.
- After a PPS-deferred request, a `pps_edge` at cycle p gives HOLD outputs at p+1.
- `adc_rst` asserted mid-sequence returns to the reset values on the next edge. The pending shadow is discarded.
- cfg_error and m_retune_tag are single-cycle pulses.

## Test plan
1. Reset release with RESET_CYCLES=16, SETTLE_SAMPLES=8 and s_dec_valid=4'b0011 every cycle -> filter_reset high for 16 cycles. The first 8 valid beats are dropped. The 9th beat appears with m_retune_tag=1, then reconfig_count=1.
2. cfg_update with ratio=50, mask=3'b101 in RUN -> both outputs update 1 cycle later, m_dec_valid is 0 until the sequence completes, and reconfig_count=2.
3. cfg_update with ratio=0 -> cfg_error pulses once, filter outputs unchanged, and state remains RUN.
4. cfg_apply_on_pps=1 with ratio=10 -> old config holds until pps_edge at cycle p. The new ratio appears and filter_reset rises at p+1.
5. A second cfg_update (ratio=20) arriving in SETTLE -> HOLD restarts for a full 16 cycles with ratio 20. reconfig_count increments once.
6. s_dec_valid=0 throughout SETTLE with SETTLE_TIMEOUT=100 -> enters RUN after 100 cycles and settle_timeout=1. The next accepted request clears it.
